sp_octet_tiled: RTL and testbench

//  Parametrised successor to the sparse octet: NUM_TG 2:4-sparse threadgroups share one activation

---
 rtl/sp_octet_pkg.sv | 34 +++
 rtl/sp_tg_lane.sv | 46 ++++
 rtl/sp_octet_tiled.sv | 106 ++++++++++
 tb/tb_sp_octet_tiled.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_octet_pkg.sv
// Shared types and helpers for the tiled sparse octet: FSM states, packing constants, saturation.
// Optional build macro SP_OCTET_SAT_EN selects saturating DW reduction (see sp_tg_lane).
package sp_octet_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_C  = 3'd1,
      FETCH   = 3'd2,
      COMPUTE = 3'd3,
      WB      = 3'd4
   } state_t;

   localparam int DW_DEF       = 16;
   localparam int LANES_PER_TG = 4;   // 2 rows x 2 cols per threadgroup
   localparam int ROWS         = 2;
   localparam int COLS         = 2;
   localparam int VALS         = 2;   // nonzeros kept per 4-element group
   localparam int ELEMS        = 4;   // elements per activation column
   localparam int IDX_W        = 2;
   localparam int RED_W        = 64;  // working width for the clamp helper

   // Clamp a signed value into the range representable in dw bits.
   function automatic logic signed [RED_W-1:0] sat_reduce(input logic signed [RED_W-1:0] v,
                                                          input int dw);
      logic signed [RED_W-1:0] hi;
      logic signed [RED_W-1:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/sp_tg_lane.sv
// One 2:4-sparse threadgroup: selects activations by index, runs four 2-term MACs and
// reduces each sum back to DW bits (saturating when SP_OCTET_SAT_EN is defined, else wrapping).
module sp_tg_lane
   import sp_octet_pkg::*;
#(
   parameter int DW = DW_DEF
)
(
   input  logic [LANES_PER_TG*DW-1:0]   acc,
   input  logic [ROWS*VALS*DW-1:0]      a,
   input  logic [ROWS*VALS*IDX_W-1:0]   idx,
   input  logic [COLS*ELEMS*DW-1:0]     b,
   output logic [LANES_PER_TG*DW-1:0]   acc_nxt
);

   localparam int PW = 2*DW;
   localparam int SW = 2*DW + 2;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [IDX_W-1:0]     i0, i1;
         logic signed [DW-1:0] w0, w1, b0, b1, acc_in;
         logic signed [PW-1:0] p0, p1;
         logic signed [SW-1:0] sum;

         assign w0     = a[(r*VALS + 0)*DW +: DW];
         assign w1     = a[(r*VALS + 1)*DW +: DW];
         assign i0     = idx[(r*VALS + 0)*IDX_W +: IDX_W];
         assign i1     = idx[(r*VALS + 1)*IDX_W +: IDX_W];
         assign b0     = b[(ELEMS*c + int'(i0))*DW +: DW];
         assign b1     = b[(ELEMS*c + int'(i1))*DW +: DW];
         assign acc_in = acc[(COLS*r + c)*DW +: DW];

         assign p0  = PW'(w0) * PW'(b0);
         assign p1  = PW'(w1) * PW'(b1);
         assign sum = SW'(acc_in) + SW'(p0) + SW'(p1);

`ifdef SP_OCTET_SAT_EN
         assign acc_nxt[(COLS*r + c)*DW +: DW] = DW'(sat_reduce(RED_W'(sum), DW));
`else
         assign acc_nxt[(COLS*r + c)*DW +: DW] = DW'(sum);
`endif
      end
   end

endmodule

// File: rtl/sp_octet_tiled.sv
// Tiled 2:4-sparse octet: NUM_TG threadgroups share an activation beat and accumulate over
// k_steps beats before returning the tile. Build macro SP_OCTET_SAT_EN enables saturation.
module sp_octet_tiled
   import sp_octet_pkg::*;
#(
   parameter int NUM_TG = 2,
   parameter int DW     = DW_DEF,
   parameter int KW     = 8
)
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic [KW-1:0]          k_steps,
   output logic                   busy,
   input  logic                   c_valid,
   output logic                   c_ready,
   input  logic [NUM_TG*4*DW-1:0] c_data,
   input  logic                   ab_valid,
   output logic                   ab_ready,
   input  logic [NUM_TG*4*DW-1:0] a_data,
   input  logic [NUM_TG*8-1:0]    idx_data,
   input  logic [8*DW-1:0]        b_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_TG*4*DW-1:0] out_data
);

   localparam int TW = NUM_TG*4*DW;

   // Handshakes: a beat transfers on a rising clk edge where valid and ready are both high;
   // ready depends only on state, and out_data stays stable while out_valid waits for out_ready.
   state_t          state, state_nxt;
   logic [TW-1:0]   acc, acc_nxt, a_q;
   logic [NUM_TG*8-1:0] idx_q;
   logic [8*DW-1:0] b_q;
   logic [KW-1:0]   step, k_lat;
   logic            c_hs, ab_hs, out_hs, last_step;

   assign c_hs      = c_valid & c_ready;
   assign ab_hs     = ab_valid & ab_ready;
   assign out_hs    = out_valid & out_ready;
   assign last_step = (step == (k_lat - KW'(1)));

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)  state_nxt = LOAD_C;
         LOAD_C:  if (c_hs)   state_nxt = FETCH;
         FETCH:   if (ab_hs)  state_nxt = COMPUTE;
         COMPUTE: state_nxt = last_step ? WB : FETCH;
         WB:      if (out_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      c_ready   = (state == LOAD_C);
      ab_ready  = (state == FETCH);
      out_valid = (state == WB);
      out_data  = (state == WB) ? acc : '0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc   <= '0;
         a_q   <= '0;
         idx_q <= '0;
         b_q   <= '0;
         step  <= '0;
         k_lat <= '0;
      end else begin
         if (state == IDLE && start) begin
            k_lat <= (k_steps == '0) ? KW'(1) : k_steps;
            step  <= '0;
         end
         if (c_hs) acc <= c_data;
         if (ab_hs) begin
            a_q   <= a_data;
            idx_q <= idx_data;
            b_q   <= b_data;
         end
         if (state == COMPUTE) begin
            acc <= acc_nxt;
            if (!last_step) step <= step + KW'(1);
         end
      end
   end

   for (genvar t = 0; t < NUM_TG; t++) begin : g_tg
      sp_tg_lane #(.DW(DW)) u_lane (
         .acc     (acc[t*4*DW +: 4*DW]),
         .a       (a_q[t*4*DW +: 4*DW]),
         .idx     (idx_q[t*8 +: 8]),
         .b       (b_q),
         .acc_nxt (acc_nxt[t*4*DW +: 4*DW])
      );
   end

endmodule

// File: tb/tb_sp_octet_tiled.sv
// Bench for sp_octet_tiled: directed and random tiles against an integer reference model.
// Honours SP_OCTET_SAT_EN so the model matches the build of the design.
module tb_sp_octet_tiled;

   localparam int NUM_TG = 2;
   localparam int DW     = 16;
   localparam int KW     = 8;
   localparam int W      = NUM_TG*4*DW;
   localparam int NL     = NUM_TG*4;
   localparam int MAXK   = 8;

   logic            clk, rstn, start, busy;
   logic [KW-1:0]   k_steps;
   logic            c_valid, c_ready, ab_valid, ab_ready, out_valid, out_ready;
   logic [W-1:0]    c_data, a_data, out_data;
   logic [NUM_TG*8-1:0] idx_data;
   logic [8*DW-1:0] b_data;

   sp_octet_tiled #(.NUM_TG(NUM_TG), .DW(DW), .KW(KW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .k_steps(k_steps), .busy(busy),
      .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
      .ab_valid(ab_valid), .ab_ready(ab_ready), .a_data(a_data), .idx_data(idx_data),
      .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int checks = 0;
   int errors = 0;

   // stimulus tables: c lanes, per-step weights/indices (slot 4t+2r+v), activations (4c+e)
   int c_arr[NL];
   int w_arr[MAXK][NL];
   int ix_arr[MAXK][NL];
   int b_arr[MAXK][8];
   logic [W-1:0] exp_q[$];

   function automatic longint reduce(input longint x);
`ifdef SP_OCTET_SAT_EN
      if (x > 32767)  return 32767;
      if (x < -32768) return -32768;
      return x;
`else
      longint m = 65536;
      longint y;
      y = ((x % m) + m) % m;
      if (y >= 32768) y = y - m;
      return y;
`endif
   endfunction

   function automatic int rnd_s16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // reference: each step, out[r][c] += sum over v of w[r][v] * bcol[c][idx[r][v]]
   task automatic model_tile(input int k);
      longint acc[NL];
      logic [W-1:0] e;
      int k_eff;
      k_eff = (k == 0) ? 1 : k;
      for (int l = 0; l < NL; l++) acc[l] = c_arr[l];
      for (int s = 0; s < k_eff; s++)
         for (int t = 0; t < NUM_TG; t++)
            for (int r = 0; r < 2; r++)
               for (int c = 0; c < 2; c++) begin
                  longint sum;
                  int row;
                  row = 4*t + 2*r;
                  sum = acc[row + c];
                  for (int v = 0; v < 2; v++)
                     sum += longint'(w_arr[s][row+v]) * longint'(b_arr[s][4*c + ix_arr[s][row+v]]);
                  acc[row + c] = reduce(sum);
               end
      e = '0;
      for (int l = 0; l < NL; l++) e[l*DW +: DW] = 16'(acc[l]);
      exp_q.push_back(e);
   endtask

   function automatic logic [W-1:0] pack_c();
      logic [W-1:0] v;
      for (int l = 0; l < NL; l++) v[l*DW +: DW] = 16'(c_arr[l]);
      return v;
   endfunction

   function automatic logic [W-1:0] pack_a(input int s);
      logic [W-1:0] v;
      for (int l = 0; l < NL; l++) v[l*DW +: DW] = 16'(w_arr[s][l]);
      return v;
   endfunction

   function automatic logic [NUM_TG*8-1:0] pack_idx(input int s);
      logic [NUM_TG*8-1:0] v;
      for (int l = 0; l < NL; l++) v[l*2 +: 2] = 2'(ix_arr[s][l]);
      return v;
   endfunction

   function automatic logic [8*DW-1:0] pack_b(input int s);
      logic [8*DW-1:0] v;
      for (int e = 0; e < 8; e++) v[e*DW +: DW] = 16'(b_arr[s][e]);
      return v;
   endfunction

   task automatic fill_random();
      for (int l = 0; l < NL; l++) c_arr[l] = rnd_s16();
      for (int s = 0; s < MAXK; s++) begin
         for (int l = 0; l < NL; l++) begin
            w_arr[s][l]  = rnd_s16();
            ix_arr[s][l] = int'($urandom_range(0, 3));
         end
         for (int e = 0; e < 8; e++) b_arr[s][e] = rnd_s16();
      end
   endtask

   task automatic apply_reset(input int n);
      rstn = 1'b0;
      repeat (n) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic timeout_fail(input string what);
      errors++;
      checks++;
      $display("FAIL timeout_%s: handshake never arrived, required within budget", what);
      start = 0; c_valid = 0; ab_valid = 0; out_ready = 0;
      apply_reset(2);
   endtask

   // Drives one tile. abort_at>0 pulls rstn low after that many accepted beats.
   task automatic run_tile(input int k, input int gap, input int hold, input bit pulse_start,
                           input bit chk_lat, input int abort_at);
      int k_eff, t0, bud;
      logic [W-1:0] held, expv;
      k_eff = (k == 0) ? 1 : k;
      model_tile(k);
      @(negedge clk);
      t0 = cyc;
      start   = 1'b1;
      k_steps = KW'(k);
      c_valid = 1'b1;
      c_data  = pack_c();
      @(negedge clk);
      start   = 1'b0;
      k_steps = KW'($urandom_range(0, 255));
      bud = 0;
      while (!c_ready && bud < 50) begin @(negedge clk); bud++; end
      if (!c_ready) begin void'(exp_q.pop_back()); timeout_fail("c_ready"); return; end
      @(negedge clk);
      c_valid = 1'b0;
      c_data  = {$urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < k_eff; s++) begin
         ab_valid = 1'b0;
         repeat (gap) @(negedge clk);
         a_data   = pack_a(s);
         idx_data = pack_idx(s);
         b_data   = pack_b(s);
         ab_valid = 1'b1;
         bud = 0;
         while (!ab_ready && bud < 50) begin @(negedge clk); bud++; end
         if (!ab_ready) begin void'(exp_q.pop_back()); timeout_fail("ab_ready"); return; end
         @(negedge clk);
         ab_valid = 1'b0;
         a_data   = {$urandom, $urandom, $urandom, $urandom};
         b_data   = {$urandom, $urandom, $urandom, $urandom};
         if (abort_at > 0 && s == abort_at - 1) begin
            void'(exp_q.pop_back());
            rstn = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, out_valid, c_ready, ab_ready} !== 4'b0000 || out_data !== '0) begin
               errors++;
               $display("FAIL abort_reset: busy/ov/cr/ar=%b out_data=%h, required 0000 and 0",
                        {busy, out_valid, c_ready, ab_ready}, out_data);
            end
            rstn = 1'b1;
            @(negedge clk);
            return;
         end
      end
      bud = 0;
      while (!out_valid && bud < 50) begin @(negedge clk); bud++; end
      if (!out_valid) begin void'(exp_q.pop_back()); timeout_fail("out_valid"); return; end
      if (chk_lat) begin
         checks++;
         if (cyc - t0 !== 2 + 2*k_eff) begin
            errors++;
            $display("FAIL latency: start->out_valid %0d cycles, required %0d", cyc - t0, 2 + 2*k_eff);
         end
      end
      held = out_data;
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start     = pulse_start;
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== held) begin
            errors++;
            $display("FAIL wb_hold: ov=%b busy=%b data=%h, required 1 1 %h", out_valid, busy, out_data, held);
         end
      end
      expv = exp_q.pop_front();
      checks++;
      if (out_data !== expv) begin
         errors++;
         $display("FAIL tile_k%0d: out_data=%h required %h", k, out_data, expv);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL after_wb: busy=%b ov=%b data=%h, required 0 0 0", busy, out_valid, out_data);
      end
   endtask

   task automatic test_reset();
      apply_reset(3);
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, c_ready, ab_ready, out_valid} !== 4'b0000 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy/cr/ar/ov=%b data=%h, required 0000 0",
                  {busy, c_ready, ab_ready, out_valid}, out_data);
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b required 0", busy);
      end
   endtask

   task automatic test_basic();
      for (int l = 0; l < NL; l++) begin
         c_arr[l]    = 0;
         w_arr[0][l] = 1;
         ix_arr[0][l] = l % 2;
      end
      for (int e = 0; e < 8; e++) b_arr[0][e] = (e % 4) + 1;
      run_tile(1, 0, 0, 1'b0, 1'b1, 0);
   endtask

   task automatic test_multi_step();
      for (int l = 0; l < NL; l++) c_arr[l] = 0;
      c_arr[0] = 10;
      for (int s = 0; s < 3; s++) begin
         for (int l = 0; l < NL; l++) begin
            w_arr[s][l]  = (l % 2 == 0) ? 2 : -1;
            ix_arr[s][l] = 3;
         end
         for (int e = 0; e < 8; e++) b_arr[s][e] = 0;
         b_arr[s][3] = 5;
      end
      run_tile(3, 0, 0, 1'b0, 1'b1, 0);
   endtask

   task automatic test_saturation();
      for (int l = 0; l < NL; l++) c_arr[l] = 32767;
      for (int l = 0; l < NL; l++) begin
         w_arr[0][l]  = 32767;
         ix_arr[0][l] = int'($urandom_range(0, 3));
      end
      for (int e = 0; e < 8; e++) b_arr[0][e] = 32767;
      run_tile(1, 0, 0, 1'b0, 1'b0, 0);
      for (int l = 0; l < NL; l++) begin
         c_arr[l]    = -32768;
         w_arr[0][l] = -32768;
      end
      run_tile(1, 0, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      fill_random();
      run_tile(2, 0, 5, 1'b1, 1'b0, 0);
   endtask

   task automatic test_k_zero_gaps();
      fill_random();
      run_tile(0, 3, 0, 1'b0, 1'b0, 0);
      fill_random();
      run_tile(3, 3, 1, 1'b0, 1'b0, 0);
   endtask

   task automatic test_reset_mid_tile();
      fill_random();
      run_tile(4, 0, 0, 1'b0, 1'b0, 2);
      fill_random();
      run_tile(4, 0, 0, 1'b0, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 10; n++) begin
         fill_random();
         run_tile(int'($urandom_range(0, MAXK)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 0);
      end
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; k_steps = '0; c_valid = 1'b0; c_data = '0;
      ab_valid = 1'b0; a_data = '0; idx_data = '0; b_data = '0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_multi_step();
      test_saturation();
      test_backpressure();
      test_k_zero_gaps();
      test_reset_mid_tile();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
